// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared defaults and FSM encoding for the bit-serial subtractor
package serial_subtractor_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int BWIDTH_DEF = 4;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_fulladder.sv
// fulladder: single-bit full adder cell shared with the ripple-carry adder
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);
  assign sum = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - zext(B) through one full adder, LSB first
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BWIDTH = BWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  A,
  input  logic [BWIDTH-1:0] B,
  output logic [WIDTH-1:0]  D,
  output logic              Bo,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] ra, rb, rd;
  logic [CW-1:0] cnt;
  logic c, s, co;
  fulladder u_fa (.a(ra[0]), .b(rb[0]), .cin(c), .cout(co), .sum(s));
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ra <= '0;
      rb <= '0;
      rd <= '0;
      cnt <= '0;
      c <= 1'b0;
      D <= '0;
      Bo <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ra <= A;
          rb <= ~WIDTH'(B);
          c <= 1'b1;
          cnt <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          ra <= ra >> 1;
          rb <= rb >> 1;
          rd <= {s, rd[WIDTH-1:1]};
          c <= co;
          cnt <= cnt + CW'(1);
          // final carry out of the two's-complement add means no borrow
          if (cnt == CW'(WIDTH - 1)) begin
            D <= {s, rd[WIDTH-1:1]};
            Bo <= ~co;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] A = '0, D;
  logic [3:0] B = '0;
  logic Bo, busy, done;
  int n_cmp = 0, n_err = 0;
  serial_subtractor dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
                         .D(D), .Bo(Bo), .busy(busy), .done(done));
  always #5 clk = ~clk;
  function automatic int exp_d(int a, int b);
    return ((a - b) % 256 + 256) % 256;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_op(input int a, input int b);
    int lat, busy_n;
    logic got, stable;
    logic [7:0] prev_d;
    logic prev_bo;
    prev_d = D;
    prev_bo = Bo;
    @(negedge clk);
    A = 8'(a);
    B = 4'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom);
    B = 4'($urandom);
    got = 1'b0;
    stable = 1'b1;
    busy_n = 0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        lat = i;
      end else begin
        if (busy) busy_n++;
        if (D !== prev_d || Bo !== prev_bo) stable = 1'b0;
        @(negedge clk);
      end
    end
    check("done_seen", got, 1);
    check("latency", lat, 8);
    check("busy_cycles", busy_n, 8);
    check("hold_during_run", stable, 1);
    check("busy_with_done", busy, 0);
    check("D", D, exp_d(a, b));
    check("Bo", Bo, a < b);
  endtask
  initial begin
    int dn, k9;
    logic held_ok;
    @(negedge clk);
    @(negedge clk);
    check("rst_D", D, 0);
    check("rst_Bo", Bo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    do_op(200, 9);
    do_op(5, 12);
    do_op(0, 0);
    do_op(255, 15);
    // extra requests during RUN and DONE must be dropped
    @(negedge clk);
    A = 8'd100;
    B = 4'd3;
    start = 1'b1;
    @(negedge clk);
    A = 8'd1;
    B = 4'd15;
    dn = 0;
    for (int i = 1; i <= 25; i++) begin
      start = (i < 9) ? i[0] : 1'b0;
      if (done) dn++;
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore_done_count", dn, 1);
    check("ignore_D", D, 97);
    check("ignore_Bo", Bo, 0);
    // reset mid-run aborts without a done pulse
    @(negedge clk);
    A = 8'd50;
    B = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_D", D, 0);
    check("abort_Bo", Bo, 0);
    check("abort_busy", busy, 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    do_op(50, 7);
    // held start re-triggers every 10 cycles
    @(negedge clk);
    A = 8'd10;
    B = 4'd10;
    start = 1'b1;
    dn = 0;
    k9 = 0;
    held_ok = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (k % 10 == 9) k9++;
      end
      if (k >= 9 && (D !== 8'd0 || Bo !== 1'b0)) held_ok = 1'b0;
    end
    start = 1'b0;
    check("held_done_count", dn, 3);
    check("held_done_phase", k9, 3);
    check("held_D_Bo_stable", held_ok, 1);
    for (int i = 0; i < 50; i++) do_op(int'($urandom_range(255)), int'($urandom_range(15)));
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++) do_op(a, b);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
